// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM->WB pipeline register with valid/ready handshake,
// optional 2-entry skid buffer (registered in_ready) and synchronous flush.
module mem_wb_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CTRL_W  = 2,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]  in_dm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_alu,
    output logic [RADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0]  out_dm,
    output logic [1:0]         occupancy
);
    localparam int PW = CTRL_W + 2 * DATA_W + RADDR_W;

    logic [PW-1:0]     in_p, out_q, out_d, skid_q, skid_d;
    logic [1:0]        occ_q, occ_d;
    logic              ready_q, ready_d, accept, emit;
    logic [CTRL_W-1:0] ctrl_held;

    assign in_p = {in_ctrl, in_alu, in_rd, in_dm};
    assign {ctrl_held, out_alu, out_rd, out_dm} = out_q;
    assign out_valid = occ_q != 2'd0;
    assign out_ctrl = out_valid ? ctrl_held : '0;
    assign occupancy = occ_q;
    assign in_ready = SKID_EN ? ready_q : (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    assign emit = out_valid && out_ready;

    // Flush drops held entries and the incoming one; payload registers keep their old bits.
    always_comb begin
        occ_d  = occ_q;
        out_d  = out_q;
        skid_d = skid_q;
        if (flush) begin
            occ_d = 2'd0;
        end else if (occ_q == 2'd0) begin
            if (accept) begin
                occ_d = 2'd1;
                out_d = in_p;
            end
        end else if (occ_q == 2'd1) begin
            if (accept && !emit) begin
                occ_d  = 2'd2;
                skid_d = in_p;
            end else if (accept) begin
                out_d = in_p;
            end else if (emit) begin
                occ_d = 2'd0;
            end
        end else if (emit) begin
            occ_d = 2'd1;
            out_d = skid_q;
        end
        ready_d = occ_d != 2'd2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q   <= '0;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: scoreboard bench for the skid build, plus a directed
// check of the pass-through-ready build.
module tb_mem_wb_pipe_reg;
    localparam int PW = 71;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  in_ctrl = '0;
    logic [31:0] in_alu = '0, in_dm = '0;
    logic [4:0]  in_rd = '0;
    logic        in_ready, out_valid;
    logic [1:0]  out_ctrl, occupancy;
    logic [31:0] out_alu, out_dm;
    logic [4:0]  out_rd;

    logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
    logic [1:0]  in_ctrl0 = '0;
    logic [31:0] in_alu0 = '0, in_dm0 = '0;
    logic [4:0]  in_rd0 = '0;
    logic        in_ready0, out_valid0;
    logic [1:0]  out_ctrl0, occupancy0;
    logic [31:0] out_alu0, out_dm0;
    logic [4:0]  out_rd0;

    mem_wb_pipe_reg #(.SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_rd(in_rd), .in_dm(in_dm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_alu(out_alu), .out_rd(out_rd), .out_dm(out_dm),
        .occupancy(occupancy)
    );

    mem_wb_pipe_reg #(.SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_ctrl(in_ctrl0), .in_alu(in_alu0), .in_rd(in_rd0), .in_dm(in_dm0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_ctrl(out_ctrl0), .out_alu(out_alu0), .out_rd(out_rd0), .out_dm(out_dm0),
        .occupancy(occupancy0)
    );

    int checks = 0;
    int failures = 0;
    logic [PW-1:0] exp_q[$];
    bit exp_rdy = 1'b1;
    bit model_acc = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rnd_p();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[PW-1:0];
    endfunction

    // Reference: the stage is an ordered queue of at most two entries.
    initial forever begin
        @(posedge clk);
        model_acc = 1'b0;
        if (!rst || flush) begin
            exp_q.delete();
        end else if (in_valid && exp_rdy) begin
            exp_q.push_back({in_ctrl, in_alu, in_rd, in_dm});
            model_acc = 1'b1;
        end
    end

    initial begin : monitor
        int n;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_rdy = 1'b1;
            end else begin
                n = exp_q.size();
                chk("occupancy", occupancy, n);
                chk("in_ready", in_ready, n < 2);
                chk("out_valid", out_valid, n > 0);
                if (n > 0) chk("out_payload", {out_ctrl, out_alu, out_rd, out_dm}, exp_q[0]);
                else chk("idle_ctrl", out_ctrl, 0);
                if (n > 0 && out_ready) void'(exp_q.pop_front());
                exp_rdy = n < 2;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [PW-1:0] p, input bit ordy, input bit fl);
        in_valid = v;
        {in_ctrl, in_alu, in_rd, in_dm} = p;
        out_ready = ordy;
        flush = fl;
    endtask

    task automatic send_until_acc(input logic [PW-1:0] p);
        int k;
        k = 0;
        drive(1'b1, p, 1'b1, 1'b0);
        do begin
            step();
            k++;
        end while (!model_acc && k < 10);
        chk("accept_timeout", model_acc, 1);
    endtask

    initial begin
        logic [PW-1:0] p0;
        int o0;
        bit r, er;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {out_valid, out_ctrl, out_alu, out_rd, out_dm, occupancy}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        drive(1'b1, {2'b01, 32'h0000_1234, 5'd5, 32'hDEAD_BEEF}, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (2) step();

        drive(1'b1, {2'b01, 32'h0000_00A1, 5'd1, 32'h0000_0A01}, 1'b0, 1'b0);
        step();
        drive(1'b1, {2'b10, 32'h0000_00B2, 5'd2, 32'h0000_0B02}, 1'b0, 1'b0);
        step();
        drive(1'b1, {2'b11, 32'h0000_00C3, 5'd3, 32'h0000_0C03}, 1'b0, 1'b0);
        repeat (2) step();
        chk("full_in_ready", in_ready, 0);
        chk("full_occupancy", occupancy, 2);
        send_until_acc({2'b11, 32'h0000_00C3, 5'd3, 32'h0000_0C03});
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (4) step();

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, rnd_p(), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (2) step();

        drive(1'b1, rnd_p(), 1'b0, 1'b0);
        step();
        drive(1'b1, rnd_p(), 1'b0, 1'b0);
        step();
        chk("pre_flush_occupancy", occupancy, 2);
        drive(1'b1, rnd_p(), 1'b0, 1'b1);
        step();
        chk("flush_occupancy", occupancy, 0);
        chk("flush_valid_ctrl", {out_valid, out_ctrl}, 0);
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step();

        drive(1'b1, rnd_p(), 1'b0, 1'b0);
        step();
        drive(1'b1, rnd_p(), 1'b0, 1'b0);
        step();
        chk("pre_reset_occupancy", occupancy, 2);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", {out_valid, out_ctrl, out_alu, out_rd, out_dm, occupancy}, 0);
        exp_q.delete();
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, rnd_p(), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (2) step();

        repeat (300) begin
            drive($urandom % 4 != 0, rnd_p(), $urandom % 3 != 0, $urandom % 20 == 0);
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step();

        o0 = 0;
        p0 = '0;
        for (int i = 0; i < 12; i++) begin
            r = (i % 2 == 0);
            {in_ctrl0, in_alu0, in_rd0, in_dm0} = rnd_p();
            in_valid0 = 1'b1;
            out_ready0 = r;
            #1;
            er = (o0 == 0) || r;
            chk("skid0_in_ready", in_ready0, er);
            chk("skid0_occupancy", occupancy0, o0);
            chk("skid0_out_valid", out_valid0, o0 != 0);
            if (o0 != 0) chk("skid0_payload", {out_ctrl0, out_alu0, out_rd0, out_dm0}, p0);
            if (er) begin
                o0 = 1;
                p0 = {in_ctrl0, in_alu0, in_rd0, in_dm0};
            end else if (o0 != 0 && r) begin
                o0 = 0;
            end
            step();
        end
        in_valid0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
